hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hz_pkg.sv | 31 +++
 rtl/hz_sat_cnt.sv | 23 ++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared encodings for pipeline-register hazard control and the hazard FSM.
// Used by the hazard unit and by every pipeline register that consumes HzCtrl.
package hz_pkg;

    typedef enum logic [1:0] {
        HZ_NORMAL = 2'b00,
        HZ_FLUSH  = 2'b01,
        HZ_STALL  = 2'b10
    } hz_ctrl_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDBUSY = 1'b1
    } hz_state_e;

    localparam int MDCNT_W = 6;
    localparam int PERF_W  = 16;

    // Load-use: EX load writes a register the ID instruction reads ($0 never hazards).
    function automatic logic is_load_use(
        input logic       mem_rd,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return mem_rd && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hz_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
module hz_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: multi-cycle mult/div stall, branch/jump flush,
// load-use stall, plus saturating stall/flush performance counters.
module hazard_ctrl
    import hz_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IF_ID_RsAddr,
    input  logic [4:0]  IF_ID_RtAddr,
    input  logic        IF_ID_UsesRt,
    input  logic        ID_EX_MemRd,
    input  logic [4:0]  ID_EX_RtAddr,
    input  logic        ID_Jump,
    input  logic        EX_BranchTaken,
    input  logic        EX_MDStart,
    output logic        PCWr,
    output logic [1:0]  IF_ID_HzCtrl,
    output logic [1:0]  ID_EX_HzCtrl,
    output logic [1:0]  EX_MEM_HzCtrl,
    output logic        MDBusy,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);

    localparam logic [MDCNT_W-1:0] MD_LOAD = MDCNT_W'(MD_CYCLES - 2);

    hz_state_e          r_state;
    logic [MDCNT_W-1:0] r_md_cnt;

    logic     w_load_use;
    logic     w_md_stall;
    logic     w_pc_wr;
    hz_ctrl_e w_if_id;
    hz_ctrl_e w_id_ex;
    hz_ctrl_e w_ex_mem;
    logic     w_stall_evt;
    logic     w_flush_evt;

    assign w_load_use = is_load_use(ID_EX_MemRd, ID_EX_RtAddr, IF_ID_RsAddr,
                                    IF_ID_RtAddr, IF_ID_UsesRt);
    assign w_md_stall = (r_state == ST_MDBUSY) || EX_MDStart;

    // Priority chain; a branch beats load-use so the loaded-over instruction is flushed.
    always_comb begin
        w_pc_wr  = 1'b1;
        w_if_id  = HZ_NORMAL;
        w_id_ex  = HZ_NORMAL;
        w_ex_mem = HZ_NORMAL;
        if (rst) begin
            w_pc_wr  = 1'b0;
            w_if_id  = HZ_FLUSH;
            w_id_ex  = HZ_FLUSH;
            w_ex_mem = HZ_FLUSH;
        end else if (w_md_stall) begin
            w_pc_wr  = 1'b0;
            w_if_id  = HZ_STALL;
            w_id_ex  = HZ_STALL;
            w_ex_mem = HZ_FLUSH;
        end else if (EX_BranchTaken) begin
            w_if_id  = HZ_FLUSH;
            w_id_ex  = HZ_FLUSH;
        end else if (w_load_use) begin
            w_pc_wr  = 1'b0;
            w_if_id  = HZ_STALL;
            w_id_ex  = HZ_FLUSH;
        end else if (ID_Jump) begin
            w_if_id  = HZ_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (EX_MDStart) begin
                        r_state  <= ST_MDBUSY;
                        r_md_cnt <= MD_LOAD;
                    end
                end
                ST_MDBUSY: begin
                    if (r_md_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_md_cnt <= r_md_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_md_cnt <= '0;
                end
            endcase
        end
    end

    assign w_stall_evt = !w_pc_wr;
    assign w_flush_evt = (r_state != ST_MDBUSY) &&
                         ((w_if_id == HZ_FLUSH) || (w_id_ex == HZ_FLUSH) ||
                          (w_ex_mem == HZ_FLUSH));

    hz_sat_cnt #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_stall_evt),
        .o_cnt (StallCnt)
    );

    hz_sat_cnt #(.WIDTH(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_flush_evt),
        .o_cnt (FlushCnt)
    );

    assign PCWr          = w_pc_wr;
    assign IF_ID_HzCtrl  = w_if_id;
    assign ID_EX_HzCtrl  = w_id_ex;
    assign EX_MEM_HzCtrl = w_ex_mem;
    assign MDBusy        = (r_state == ST_MDBUSY);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_CYCLES=4.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr;
    logic        IF_ID_UsesRt, ID_EX_MemRd, ID_Jump, EX_BranchTaken, EX_MDStart;
    logic        PCWr, MDBusy;
    logic [1:0]  IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl;
    logic [15:0] StallCnt, FlushCnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_RsAddr   (IF_ID_RsAddr),
        .IF_ID_RtAddr   (IF_ID_RtAddr),
        .IF_ID_UsesRt   (IF_ID_UsesRt),
        .ID_EX_MemRd    (ID_EX_MemRd),
        .ID_EX_RtAddr   (ID_EX_RtAddr),
        .ID_Jump        (ID_Jump),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_MDStart     (EX_MDStart),
        .PCWr           (PCWr),
        .IF_ID_HzCtrl   (IF_ID_HzCtrl),
        .ID_EX_HzCtrl   (ID_EX_HzCtrl),
        .EX_MEM_HzCtrl  (EX_MEM_HzCtrl),
        .MDBusy         (MDBusy),
        .StallCnt       (StallCnt),
        .FlushCnt       (FlushCnt)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packs {PCWr, IF_ID, ID_EX, EX_MEM} into one 7-bit word for a single compare.
    task automatic chk_out(input string tag, input logic pc, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] c);
        chk(tag, {9'd0, PCWr, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl},
                 {9'd0, pc, a, b, c});
        $display("step %s: PCWr=%0b IF_ID=%b ID_EX=%b EX_MEM=%b MDBusy=%0b Stall=%0h Flush=%0h",
                 tag, PCWr, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl, MDBusy, StallCnt, FlushCnt);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mem_rd, input logic [4:0] ex_rt, input logic jmp,
                         input logic br, input logic md);
        IF_ID_RsAddr   = rs;
        IF_ID_RtAddr   = rt;
        IF_ID_UsesRt   = uses_rt;
        ID_EX_MemRd    = mem_rd;
        ID_EX_RtAddr   = ex_rt;
        ID_Jump        = jmp;
        EX_BranchTaken = br;
        EX_MDStart     = md;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset: outputs forced to PCWr=0 and all flush while rst is high.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("rst_out", 1'b0, 2'b01, 2'b01, 2'b01);
        tick();
        chk("rst_stall", StallCnt, 16'h0);
        chk("rst_flush", FlushCnt, 16'h0);
        chk("rst_busy", {15'd0, MDBusy}, 16'h0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("normal", 1'b1, 2'b00, 2'b00, 2'b00);
        tick();

        // lw $8 in EX, ID reads Rs=$8: one stall cycle then normal.
        drive(8, 3, 1, 1, 8, 0, 0, 0);
        chk_out("lu_rs", 1'b0, 2'b10, 2'b01, 2'b00);
        tick();
        drive(8, 3, 1, 0, 8, 0, 0, 0);
        chk_out("lu_after", 1'b1, 2'b00, 2'b00, 2'b00);
        chk("lu_stallcnt", StallCnt, 16'd1);
        chk("lu_flushcnt", FlushCnt, 16'd1);

        // $0 destination never hazards; Rt only matters when UsesRt is set.
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        chk_out("lu_zero", 1'b1, 2'b00, 2'b00, 2'b00);
        drive(4, 9, 0, 1, 9, 0, 0, 0);
        chk_out("lu_rt_unused", 1'b1, 2'b00, 2'b00, 2'b00);
        drive(4, 9, 1, 1, 9, 0, 0, 0);
        chk_out("lu_rt_used", 1'b0, 2'b10, 2'b01, 2'b00);
        tick();
        chk("lu2_stallcnt", StallCnt, 16'd2);

        // Jump alone, then jump under a load-use (load-use wins).
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk_out("jump", 1'b1, 2'b01, 2'b00, 2'b00);
        tick();
        chk("jump_flushcnt", FlushCnt, 16'd3);
        drive(5, 0, 0, 1, 5, 1, 0, 0);
        chk_out("lu_over_jump", 1'b0, 2'b10, 2'b01, 2'b00);

        // Branch and load-use together: branch flush, no stall.
        do_reset();
        drive(7, 0, 0, 1, 7, 0, 1, 0);
        chk_out("br_lu", 1'b1, 2'b01, 2'b01, 2'b00);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_lu_flush", FlushCnt, 16'd1);
        chk("br_lu_stall", StallCnt, 16'd0);

        // MD op, MD_CYCLES=4: 4 stall cycles, MDBusy for the last 3; branch ignored while busy.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        chk_out("md_start", 1'b0, 2'b10, 2'b10, 2'b01);
        chk("md_start_busy", {15'd0, MDBusy}, 16'd0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(6, 0, 0, 1, 6, 1, 1, 1);
            chk_out($sformatf("md_busy%0d", i), 1'b0, 2'b10, 2'b10, 2'b01);
            chk($sformatf("md_busy%0d_flag", i), {15'd0, MDBusy}, 16'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("md_done", 1'b1, 2'b00, 2'b00, 2'b00);
        chk("md_done_busy", {15'd0, MDBusy}, 16'd0);
        chk("md_stallcnt", StallCnt, 16'd4);
        chk("md_flushcnt", FlushCnt, 16'd1);

        // Reset on the second MDBUSY cycle aborts the stall.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("abort_busy_pre", {15'd0, MDBusy}, 16'd1);
        rst = 1'b1;
        #1;
        chk_out("abort_rst", 1'b0, 2'b01, 2'b01, 2'b01);
        tick();
        rst = 1'b0;
        #1;
        chk_out("abort_after", 1'b1, 2'b00, 2'b00, 2'b00);
        chk("abort_busy", {15'd0, MDBusy}, 16'd0);
        chk("abort_stall", StallCnt, 16'd0);
        chk("abort_flush", FlushCnt, 16'd0);
        tick();
        chk_out("abort_no_residual", 1'b1, 2'b00, 2'b00, 2'b00);

        // Saturation: hold a load-use until StallCnt reaches FFFE, then 3 more.
        do_reset();
        drive(2, 0, 0, 1, 2, 0, 0, 0);
        repeat (65534) tick();
        chk("sat_fffe", StallCnt, 16'hFFFE);
        tick();
        chk("sat_ffff1", StallCnt, 16'hFFFF);
        tick();
        tick();
        chk("sat_ffff3", StallCnt, 16'hFFFF);
        chk("sat_flush", FlushCnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
